writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_regfile.sv | 31 +++
 rtl/writeback_unit.sv | 103 ++++++++++
 tb/tb_writeback_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback unit: execute-bus layout and FSM state type.
// Optional feature macro used by writeback_unit: WB_BYPASS_EN.
package wb_pkg;

    localparam int unsigned WB_W      = 71;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned FCNT_W    = 3;

    localparam int unsigned WB_DATA_LSB = 0;
    localparam int unsigned WB_DATA_MSB = 31;
    localparam int unsigned WB_PC_LSB   = 32;
    localparam int unsigned WB_PC_MSB   = 63;
    localparam int unsigned WB_DEST_LSB = 64;
    localparam int unsigned WB_DEST_MSB = 68;
    localparam int unsigned WB_BR_BIT   = 69;
    localparam int unsigned WB_WEN_BIT  = 70;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_regfile.sv
// 32x32 register file: one write port, two combinational read ports, r0 hardwired to zero.
module wb_regfile
    import wb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [XLEN-1:0]   rdata_a_o,
    output logic [XLEN-1:0]   rdata_b_o
);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: register file update, branch redirect and upstream flush sequencing.
// Define WB_BYPASS_EN to forward the same-cycle write data onto matching read ports.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WB_W-1:0]   ex_wb,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [XLEN-1:0]   rs_data,
    output logic [XLEN-1:0]   rt_data,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush,
    output logic [XLEN-1:0]   retired
);

    logic [XLEN-1:0]   wb_data;
    logic [XLEN-1:0]   wb_pc;
    logic [REG_AW-1:0] wb_dest;
    logic              wb_br;
    logic              wb_wen;

    assign wb_data = ex_wb[WB_DATA_MSB:WB_DATA_LSB];
    assign wb_pc   = ex_wb[WB_PC_MSB:WB_PC_LSB];
    assign wb_dest = ex_wb[WB_DEST_MSB:WB_DEST_LSB];
    assign wb_br   = ex_wb[WB_BR_BIT];
    assign wb_wen  = ex_wb[WB_WEN_BIT];

    wb_state_e         state_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic              redirect_valid_q;
    logic [XLEN-1:0]   redirect_pc_q;
    logic [XLEN-1:0]   retired_q;
    logic [XLEN-1:0]   retired_d;
    logic              accept;
    logic              rf_we;

    assign accept    = ex_valid && (state_q == ST_RUN);
    assign rf_we     = accept && wb_wen && (wb_dest != '0);
    assign retired_d = retired_q + 32'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_RUN;
            fcnt_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            retired_q        <= '0;
        end else begin
            redirect_valid_q <= 1'b0;
            if (accept) begin
                retired_q <= retired_d;
                if (wb_br) begin
                    redirect_pc_q    <= wb_pc;
                    redirect_valid_q <= 1'b1;
                    state_q          <= ST_FLUSH;
                    fcnt_q           <= FCNT_W'(FLUSH_CYCLES - 1);
                end
            end else if (state_q == ST_FLUSH) begin
                // Counter holds remaining flush cycles after the current one.
                if (fcnt_q == '0) begin
                    state_q <= ST_RUN;
                end else begin
                    fcnt_q <= fcnt_q - 1'b1;
                end
            end
        end
    end

    logic [XLEN-1:0] rs_rf;
    logic [XLEN-1:0] rt_rf;

    wb_regfile u_regfile (
        .clk_i     (clock),
        .rst_i     (reset),
        .we_i      (rf_we),
        .waddr_i   (wb_dest),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_addr),
        .raddr_b_i (rt_addr),
        .rdata_a_o (rs_rf),
        .rdata_b_o (rt_rf)
    );

`ifdef WB_BYPASS_EN
    assign rs_data = (rf_we && (rs_addr == wb_dest)) ? wb_data : rs_rf;
    assign rt_data = (rf_we && (rt_addr == wb_dest)) ? wb_data : rt_rf;
`else
    assign rs_data = rs_rf;
    assign rt_data = rt_rf;
`endif

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = (state_q == ST_FLUSH);
    assign retired        = retired_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of architectural state.
module tb_writeback_unit;

    localparam int unsigned FC = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [70:0] ex_wb;
    logic        ex_valid;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] retired;

    always #5 clock = ~clock;

    writeback_unit #(.FLUSH_CYCLES(FC)) dut (
        .clock          (clock),
        .reset          (reset),
        .ex_wb          (ex_wb),
        .ex_valid       (ex_valid),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .retired        (retired)
    );

    // Reference model: architectural state plus number of flush cycles still to run.
    logic [31:0] m_regs [32];
    logic [31:0] m_retired;
    logic [31:0] m_rpc;
    bit          m_rv;
    int          m_flush_left;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [70:0] mk(input bit wen, input bit br, input logic [4:0] dest,
                                       input logic [31:0] pc, input logic [31:0] data);
        return {wen, br, dest, pc, data};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_retired    = '0;
        m_rpc        = '0;
        m_rv         = 1'b0;
        m_flush_left = 0;
    endtask

    function automatic bit writing_now();
        return ex_valid && (m_flush_left == 0) && ex_wb[70] && (ex_wb[68:64] != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
`ifdef WB_BYPASS_EN
        if (writing_now() && (a == ex_wb[68:64])) return ex_wb[31:0];
`endif
        return (a == 5'd0) ? 32'd0 : m_regs[a];
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_rs"},    rs_data, exp_read(rs_addr));
        check({tag, "_rt"},    rt_data, exp_read(rt_addr));
        check({tag, "_rv"},    {31'd0, redirect_valid}, {31'd0, m_rv});
        check({tag, "_rpc"},   redirect_pc, m_rpc);
        check({tag, "_flush"}, {31'd0, flush}, {31'd0, m_flush_left > 0});
        check({tag, "_ret"},   retired, m_retired);
    endtask

    // Apply the effect of the current inputs at the clock edge just taken.
    task automatic model_edge();
        bit acc;
        acc  = ex_valid && (m_flush_left == 0);
        m_rv = 1'b0;
        if (m_flush_left > 0) m_flush_left--;
        if (acc) begin
            m_retired = m_retired + 1;
            if (ex_wb[70] && ex_wb[68:64] != 5'd0) m_regs[ex_wb[68:64]] = ex_wb[31:0];
            if (ex_wb[69]) begin
                m_rpc        = ex_wb[63:32];
                m_rv         = 1'b1;
                m_flush_left = FC;
            end
        end
    endtask

    // Called just after a rising edge: drive, check at the falling edge, take the next edge.
    task automatic cycle(input string tag, input bit v, input logic [70:0] w,
                         input logic [4:0] ra, input logic [4:0] rb);
        ex_valid = v;
        ex_wb    = w;
        rs_addr  = ra;
        rt_addr  = rb;
        @(negedge clock);
        check_outputs(tag);
        @(posedge clock);
        model_edge();
        #1;
    endtask

    initial begin
        logic [31:0] ret_save;
        logic [31:0] old7;

        reset    = 1'b1;
        ex_valid = 1'b0;
        ex_wb    = '0;
        rs_addr  = '0;
        rt_addr  = '0;
        model_reset();

        #12;
        check_outputs("reset");
        rs_addr = 5'd31;
        rt_addr = 5'd1;
        #1;
        check("reset_r31", rs_data, 32'd0);
        check("reset_r1",  rt_data, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Write then read.
        cycle("wr5", 1'b1, mk(1, 0, 5'd5, 32'd0, 32'h12345678), 5'd5, 5'd0);
        rs_addr = 5'd5;
        #1;
        check("req028_rs",  rs_data, 32'h12345678);
        check("req028_ret", retired, 32'd1);

        // Register 0 ignores writes.
        cycle("wr0", 1'b1, mk(1, 0, 5'd0, 32'd0, 32'hFFFFFFFF), 5'd0, 5'd0);
        rs_addr = 5'd0;
        #1;
        check("req029_r0",  rs_data, 32'd0);
        check("req029_ret", retired, 32'd2);

        // Branch with drops during flush.
        cycle("br", 1'b1, mk(0, 1, 5'd0, 32'h00000040, 32'd0), 5'd0, 5'd0);
        check("req030_rv",    {31'd0, redirect_valid}, 32'd1);
        check("req030_rpc",   redirect_pc, 32'h00000040);
        check("req030_fl1",   {31'd0, flush}, 32'd1);
        ret_save = retired;
        cycle("drop1", 1'b1, mk(1, 0, 5'd9, 32'd0, 32'hDEADBEEF), 5'd9, 5'd5);
        check("req030_rv_lo", {31'd0, redirect_valid}, 32'd0);
        check("req030_fl2",   {31'd0, flush}, 32'd1);
        cycle("drop2", 1'b1, mk(1, 1, 5'd5, 32'h00000080, 32'hCAFEF00D), 5'd9, 5'd5);
        check("req030_fl_end", {31'd0, flush}, 32'd0);
        check("req030_ret",    retired, ret_save);
        check("req030_rpc2",   redirect_pc, 32'h00000040);
        rs_addr = 5'd9;
        rt_addr = 5'd5;
        #1;
        check("req030_r9", rs_data, 32'd0);
        check("req030_r5", rt_data, 32'h12345678);

        // Same-cycle read of the register being written.
        cycle("wr7", 1'b1, mk(1, 0, 5'd7, 32'd0, 32'h11111111), 5'd0, 5'd0);
        old7     = 32'h11111111;
        ex_valid = 1'b1;
        ex_wb    = mk(1, 0, 5'd7, 32'd0, 32'hAAAAAAAA);
        rt_addr  = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        check("req031_byp", rt_data, 32'hAAAAAAAA);
`else
        check("req031_byp", rt_data, old7);
`endif
        @(negedge clock);
        check_outputs("byp");
        @(posedge clock);
        model_edge();
        #1;
        check("req031_after", rt_data, 32'hAAAAAAAA);

        // Reset during the first flush cycle.
        cycle("br2", 1'b1, mk(1, 1, 5'd3, 32'h00001234, 32'h00000033), 5'd0, 5'd0);
        check("req032_pre_fl", {31'd0, flush}, 32'd1);
        ex_valid = 1'b0;
        reset    = 1'b1;
        #1;
        model_reset();
        check("req032_flush", {31'd0, flush}, 32'd0);
        check("req032_rv",    {31'd0, redirect_valid}, 32'd0);
        check("req032_rpc",   redirect_pc, 32'd0);
        check("req032_ret",   retired, 32'd0);
        rs_addr = 5'd3;
        rt_addr = 5'd7;
        #1;
        check("req032_r3", rs_data, 32'd0);
        check("req032_r7", rt_data, 32'd0);
        @(negedge clock);
        reset    = 1'b0;
        ex_valid = 1'b1;
        ex_wb    = mk(1, 0, 5'd3, 32'd0, 32'h0BADCAFE);
        @(posedge clock);
        model_edge();
        #1;
        check("req032_acc_ret", retired, 32'd1);
        check("req032_acc_r3",  rs_data, 32'h0BADCAFE);

        // Retired counter wrap.
        cycle("idle", 1'b0, '0, 5'd0, 5'd0);
        @(negedge clock);
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        m_retired = 32'hFFFFFFFF;
        check("req033_pre", retired, 32'hFFFFFFFF);
        @(posedge clock);
        #1;
        cycle("wrap", 1'b1, mk(0, 0, 5'd0, 32'd0, 32'd0), 5'd0, 5'd0);
        check("req033_wrap", retired, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit          v;
            bit          br;
            bit          wen;
            logic [4:0]  dst;
            logic [4:0]  ra;
            logic [4:0]  rb;
            v   = ($urandom_range(0, 9) < 7);
            br  = ($urandom_range(0, 19) < 3);
            wen = ($urandom_range(0, 9) < 6);
            dst = 5'($urandom_range(0, 31));
            ra  = ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 31));
            rb  = ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 31));
            cycle("rnd", v, mk(wen, br, dst, $urandom, $urandom), ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
